// File: rtl/ls_pkg.sv
// Shared constants for the load/store unit: funct3 codes and FSM states.
// Optional watchdog is enabled with LS_TIMEOUT_EN.
package ls_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } ls_state_e;

endpackage

// File: rtl/ls_if.sv
// Data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface ls_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
);
  logic              ls_o_cyc;
  logic              ls_o_stb;
  logic              ls_o_we;
  logic              ls_o_rd;
  logic [AWIDTH-1:0] ls_o_load_addr;
  logic [AWIDTH-1:0] ls_o_store_addr;
  logic [DWIDTH-1:0] ls_o_data_store;
  logic [3:0]        ls_o_byte_enable;
  logic [DWIDTH-1:0] ls_i_read_data;
  logic              ls_i_ack;
  logic              ls_i_stall;

  modport master (
    output ls_o_cyc, ls_o_stb, ls_o_we, ls_o_rd,
    output ls_o_load_addr, ls_o_store_addr,
    output ls_o_data_store, ls_o_byte_enable,
    input  ls_i_read_data, ls_i_ack, ls_i_stall
  );

  modport slave (
    input  ls_o_cyc, ls_o_stb, ls_o_we, ls_o_rd,
    input  ls_o_load_addr, ls_o_store_addr,
    input  ls_o_data_store, ls_o_byte_enable,
    output ls_i_read_data, ls_i_ack, ls_i_stall
  );
endinterface

// File: rtl/ls_align.sv
// Byte-lane steering: store lane enables/replication, load
// extraction with sign/zero extension, and alignment check.
module ls_align
  import ls_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic        store_i,
  input  logic [31:0] sd_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] sdata_o,
  output logic [31:0] ldata_o,
  output logic        mis_o
);

  logic        is_b;
  logic        is_h;
  logic        sx;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign is_b   = funct3_i[1:0] == F3_LB[1:0];
  assign is_h   = funct3_i[1:0] == F3_LH[1:0];
  assign sx     = ~funct3_i[2];
  assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
  assign half_v = off_i[1] ? rdata_i[31:16]
                           : rdata_i[15:0];

  // Undefined funct3 codes fall through to word handling.
  always_comb begin
    be_o    = 4'b1111;
    sdata_o = sd_i;
    ldata_o = rdata_i;
    mis_o   = off_i != 2'b00;
    unique case (1'b1)
      is_b: begin
        mis_o   = 1'b0;
        ldata_o = {{24{sx & byte_v[7]}}, byte_v};
        if (store_i) begin
          be_o    = 4'b0001 << off_i;
          sdata_o = {4{sd_i[7:0]}};
        end
      end
      is_h: begin
        mis_o   = off_i[0];
        ldata_o = {{16{sx & half_v[15]}}, half_v};
        if (store_i) begin
          be_o    = 4'b0011 << off_i;
          sdata_o = {2{sd_i[15:0]}};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: request capture, bus handshake, load
// writeback. Define LS_TIMEOUT_EN for the WAIT watchdog / ls_o_bus_err.
module load_store_unit
  import ls_pkg::*;
#(
  parameter int AWIDTH         = 5,
  parameter int DWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              ls_clk,
  input  logic              ls_rst,
  input  logic              ls_i_valid,
  input  logic              ls_i_load,
  input  logic              ls_i_store,
  input  logic [2:0]        ls_i_funct3,
  input  logic [31:0]       ls_i_addr,
  input  logic [DWIDTH-1:0] ls_i_store_data,
  input  logic [4:0]        ls_i_rd_addr,
  output logic              ls_o_ready,
  output logic              ls_o_stall,
  output logic              ls_o_valid,
  output logic [DWIDTH-1:0] ls_o_load_data,
  output logic [4:0]        ls_o_rd_addr,
  output logic              ls_o_we_rd,
  output logic              ls_o_misaligned,
`ifdef LS_TIMEOUT_EN
  output logic              ls_o_bus_err,
`endif
  ls_if.master              bus
);

  ls_state_e           state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          f3_q, f3_d;
  logic [AWIDTH+1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   sd_q, sd_d;
  logic [4:0]          rd_q, rd_d;
  logic                mis_q, mis_d;
  logic [DWIDTH-1:0]   ld_q, ld_d;
  logic                err;

`ifdef LS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign err          = err_q;
  assign ls_o_bus_err = (state_q == ST_RESP) & err_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^ls_i_addr[31:AWIDTH+2];

  logic        idle;
  logic        busy;
  logic        accept;
  logic [2:0]  f3_s;
  logic [1:0]  off_s;
  logic        st_s;
  logic [31:0] sd_s;
  logic [3:0]  a_be;
  logic [31:0] a_sdata;
  logic [31:0] a_ldata;
  logic        a_mis;

  assign idle   = state_q == ST_IDLE;
  assign busy   = (state_q == ST_REQ)
                | (state_q == ST_WAIT);
  assign accept = ls_i_valid
                & (ls_i_load | ls_i_store);

  // Aligner sees the live request in IDLE, the captured one after.
  assign f3_s  = idle ? ls_i_funct3 : f3_q;
  assign off_s = idle ? ls_i_addr[1:0] : addr_q[1:0];
  assign st_s  = idle ? ls_i_store : store_q;
  assign sd_s  = idle ? ls_i_store_data : sd_q;

  ls_align u_align (
    .funct3_i (f3_s),
    .off_i    (off_s),
    .store_i  (st_s),
    .sd_i     (sd_s),
    .rdata_i  (bus.ls_i_read_data),
    .be_o     (a_be),
    .sdata_o  (a_sdata),
    .ldata_o  (a_ldata),
    .mis_o    (a_mis)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    sd_d    = sd_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    ld_d    = ld_q;
`ifdef LS_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          store_d = ls_i_store;
          f3_d    = ls_i_funct3;
          addr_d  = ls_i_addr[AWIDTH+1:0];
          sd_d    = ls_i_store_data;
          rd_d    = ls_i_rd_addr;
          mis_d   = a_mis;
          ld_d    = '0;
`ifdef LS_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = a_mis ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (!bus.ls_i_stall) begin
          state_d = ST_WAIT;
`ifdef LS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (bus.ls_i_ack) begin
          ld_d    = store_q ? '0 : a_ldata;
          state_d = ST_RESP;
        end
`ifdef LS_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ls_clk) begin
    if (ls_rst) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      sd_q    <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      ld_q    <= '0;
`ifdef LS_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      ld_q    <= ld_d;
`ifdef LS_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ls_o_ready      = idle;
  assign ls_o_stall      = ~idle;
  assign ls_o_valid      = state_q == ST_RESP;
  assign ls_o_load_data  = ls_o_valid ? ld_q : '0;
  assign ls_o_rd_addr    = rd_q;
  assign ls_o_misaligned = ls_o_valid & mis_q;
  assign ls_o_we_rd      = ls_o_valid & ~store_q
                         & ~mis_q & ~err;

  // we/rd stay valid through WAIT; stb only in REQ.
  assign bus.ls_o_cyc         = busy;
  assign bus.ls_o_stb         = state_q == ST_REQ;
  assign bus.ls_o_we          = busy & store_q;
  assign bus.ls_o_rd          = busy & ~store_q;
  assign bus.ls_o_load_addr   = busy ? addr_q[AWIDTH+1:2] : '0;
  assign bus.ls_o_store_addr  = busy ? addr_q[AWIDTH+1:2] : '0;
  assign bus.ls_o_data_store  = (busy & store_q) ? a_sdata : '0;
  assign bus.ls_o_byte_enable = busy ? a_be : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a word-array
// reference model; LS_TIMEOUT_EN adds the watchdog scenario.
module tb_load_store_unit;
  import ls_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i, ld_i, st_i;
  logic [2:0]  f3_i;
  logic [31:0] addr_i, sd_i;
  logic [4:0]  rd_i;
  logic        rdy_o, stl_o, val_o;
  logic [31:0] ldat_o;
  logic [4:0]  rd_o;
  logic        werd_o, mis_o;
`ifdef LS_TIMEOUT_EN
  logic        berr_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ls_if #(.AWIDTH(5), .DWIDTH(32)) bus ();

  load_store_unit #(
    .AWIDTH(5), .DWIDTH(32)
`ifdef LS_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .ls_clk          (clk),
    .ls_rst          (rst),
    .ls_i_valid      (v_i),
    .ls_i_load       (ld_i),
    .ls_i_store      (st_i),
    .ls_i_funct3     (f3_i),
    .ls_i_addr       (addr_i),
    .ls_i_store_data (sd_i),
    .ls_i_rd_addr    (rd_i),
    .ls_o_ready      (rdy_o),
    .ls_o_stall      (stl_o),
    .ls_o_valid      (val_o),
    .ls_o_load_data  (ldat_o),
    .ls_o_rd_addr    (rd_o),
    .ls_o_we_rd      (werd_o),
    .ls_o_misaligned (mis_o),
`ifdef LS_TIMEOUT_EN
    .ls_o_bus_err    (berr_o),
`endif
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: capture, execute, ack in the next cycle.
  logic [31:0] mem [32];
  bit          s_phase = 1'b0;
  bit          s_ack   = 1'b0;
  bit          s_we    = 1'b0;
  bit          s_mute  = 1'b0;
  logic [4:0]  s_addr  = '0;
  logic [31:0] s_data  = '0;
  logic [3:0]  s_be    = '0;
  logic [31:0] s_rdata = '0;
  int          caps    = 0;
  int          acks    = 0;
  logic        stall_drv;

  assign bus.ls_i_ack       = s_ack;
  assign bus.ls_i_read_data = s_rdata;
  assign bus.ls_i_stall     = stall_drv;

  always @(posedge clk) begin
    if (s_phase) begin
      s_phase <= 1'b0;
      if (!s_mute) begin
        s_ack <= 1'b1;
        acks  <= acks + 1;
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_be[b])
              mem[s_addr][8*b +: 8] <= s_data[8*b +: 8];
        end else begin
          s_rdata <= mem[s_addr];
        end
      end
    end else begin
      s_ack <= 1'b0;
      if (bus.ls_o_cyc && bus.ls_o_stb && !stall_drv) begin
        s_phase <= 1'b1;
        s_we    <= bus.ls_o_we;
        s_addr  <= bus.ls_o_store_addr;
        s_data  <= bus.ls_o_data_store;
        s_be    <= bus.ls_o_byte_enable;
        caps    <= caps + 1;
      end
    end
  end

  logic [31:0] ref_mem [32];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int kind_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 0;
    if (f3[1:0] == 2'b01) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] ref_load(
      input logic [31:0] word, input logic [2:0] f3,
      input logic [1:0] off);
    logic [31:0] sh, r;
    sh = word >> (8 * off);
    case (kind_of(f3))
      0: begin
        r = sh & 32'hFF;
        if (!f3[2] && r[7]) r = r | 32'hFFFF_FF00;
      end
      1: begin
        r = sh & 32'hFFFF;
        if (!f3[2] && r[15]) r = r | 32'hFFFF_0000;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  task automatic do_op(input logic st, input logic ld,
                       input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] sd,
                       input logic [4:0] rd,
                       input int nstall,
                       output logic [31:0] res);
    int k, t_val, n_stb, n_cyc, c0, kd;
    logic [1:0]  off;
    logic [4:0]  w;
    bit          mis;
    logic [31:0] m, e_res, e_be, e_dat;
    logic [31:0] g_be, g_dat, g_sa;
    logic        g_mis, g_werd;
    logic [4:0]  g_rd;
    off = addr[1:0];
    w   = addr[6:2];
    kd  = kind_of(f3);
    mis = (kd == 1 && off[0]) || (kd == 2 && off != 0);
    @(negedge clk);
    v_i = 1'b1; st_i = st; ld_i = ld; f3_i = f3;
    addr_i = addr; sd_i = sd; rd_i = rd;
    c0 = caps;
    @(posedge clk);
    t_val = 0; n_stb = 0; n_cyc = 0;
    g_be = 0; g_dat = 0; g_sa = 0; res = 0;
    g_mis = 0; g_werd = 0; g_rd = 0;
    for (k = 1; k <= 40 && t_val == 0; k++) begin
      @(negedge clk);
      v_i = 1'b0;
      stall_drv = (k <= nstall);
      if (bus.ls_o_cyc) n_cyc++;
      if (bus.ls_o_stb) begin
        n_stb++;
        g_be  = 32'(bus.ls_o_byte_enable);
        g_dat = bus.ls_o_data_store;
        g_sa  = 32'(bus.ls_o_store_addr);
      end
      if (val_o) begin
        t_val = k;
        res = ldat_o; g_mis = mis_o;
        g_werd = werd_o; g_rd = rd_o;
      end
    end
    stall_drv = 1'b0;
    e_res = (st || mis) ? 32'h0
          : ref_load(ref_mem[w], f3, off);
    check("valid_lat", t_val, mis ? 1 : 4 + nstall);
    check("stb_cycles", n_stb, mis ? 0 : 1 + nstall);
    check("misaligned", 32'(g_mis), 32'(mis));
    check("we_rd", 32'(g_werd), 32'(!st && !mis));
    check("rd_echo", 32'(g_rd), 32'(rd));
    check("load_data", res, e_res);
    if (mis) check("no_cyc", n_cyc, 0);
    else check("mem_caps", caps - c0, 1);
    if (st && !mis) begin
      case (kd)
        0: begin
          e_be  = 32'h1 << off;
          e_dat = (sd & 32'hFF) * 32'h0101_0101;
          m     = 32'hFF << (8 * off);
        end
        1: begin
          e_be  = 32'h3 << off;
          e_dat = (sd & 32'hFFFF) * 32'h0001_0001;
          m     = 32'hFFFF << (8 * off);
        end
        default: begin
          e_be = 32'hF; e_dat = sd; m = 32'hFFFF_FFFF;
        end
      endcase
      check("st_be", g_be, e_be);
      check("st_data", g_dat, e_dat);
      check("st_addr", g_sa, 32'(w));
      ref_mem[w] = (ref_mem[w] & ~m) | (e_dat & m);
    end else if (!mis) begin
      check("ld_be", g_be, 32'hF);
    end
    @(negedge clk);
    check("valid_pulse", 32'(val_o), 0);
  endtask

  logic [31:0] r;
  logic [2:0]  f3r;
  bit          got_v;
  int          a0, c0;

  initial begin
    rst = 1'b1; v_i = 0; ld_i = 0; st_i = 0;
    f3_i = 0; addr_i = 0; sd_i = 0; rd_i = 0;
    stall_drv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(rdy_o), 1);
    check("rst_outs", 32'({stl_o, val_o, werd_o, mis_o}), 0);
    check("rst_bus", 32'({bus.ls_o_cyc, bus.ls_o_stb,
                          bus.ls_o_we, bus.ls_o_rd}), 0);
    check("rst_ldata", ldat_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++)
      do_op(1, 0, F3_LW, 32'(i * 4), $urandom, 5'(i), 0, r);

    do_op(1, 0, F3_LW, 32'h4, 32'h8070_F0FF, 0, 0, r);
    do_op(0, 1, F3_LB, 32'h4, 0, 5'd3, 0, r);
    check("lb_plan", r, 32'hFFFF_FFFF);
    do_op(0, 1, F3_LBU, 32'h5, 0, 5'd4, 0, r);
    check("lbu_plan", r, 32'h0000_00F0);
    do_op(0, 1, F3_LH, 32'h6, 0, 5'd5, 0, r);
    check("lh_plan", r, 32'hFFFF_8070);
    do_op(0, 1, F3_LHU, 32'h6, 0, 5'd6, 0, r);
    check("lhu_plan", r, 32'h0000_8070);
    do_op(0, 1, F3_LW, 32'h4, 0, 5'd7, 3, r);
    check("lw_stall_plan", r, 32'h8070_F0FF);
    do_op(1, 0, F3_LB, 32'h6, 32'hA5, 5'd1, 0, r);
    do_op(0, 1, F3_LW, 32'h2, 0, 5'd8, 0, r);
    do_op(1, 0, F3_LH, 32'h3, 32'h1234, 5'd9, 0, r);
    do_op(1, 1, F3_LW, 32'h8, 32'hDEAD_BEEF, 5'd10, 0, r);
    do_op(0, 1, 3'b011, 32'h8, 0, 5'd11, 0, r);
    check("undef_f3_w", r, 32'hDEAD_BEEF);

    @(negedge clk);
    v_i = 1'b1; ld_i = 0; st_i = 0; c0 = caps;
    repeat (3) begin
      @(negedge clk);
      check("ignored_ready", 32'(rdy_o), 1);
    end
    v_i = 1'b0;
    check("ignored_caps", caps - c0, 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(1)) begin
        f3r = 3'($urandom_range(2));
        do_op(1, $urandom_range(1), f3r, $urandom, $urandom,
              5'($urandom), $urandom_range(2), r);
      end else begin
        case ($urandom_range(5))
          0: f3r = F3_LB;  1: f3r = F3_LH;
          2: f3r = F3_LW;  3: f3r = F3_LBU;
          4: f3r = F3_LHU; default: f3r = 3'b110;
        endcase
        do_op(0, 1, f3r, $urandom, 0, 5'($urandom),
              $urandom_range(2), r);
      end
    end

    @(negedge clk);
    v_i = 1'b1; ld_i = 1'b1; st_i = 1'b0;
    f3_i = F3_LW; addr_i = 32'h10; a0 = acks;
    @(negedge clk);
    v_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_bus", 32'({bus.ls_o_cyc, bus.ls_o_stb,
                              bus.ls_o_we, bus.ls_o_rd}), 0);
    check("rst_mid_ready", 32'(rdy_o), 1);
    got_v = 1'b0;
    repeat (6) begin
      if (val_o) got_v = 1'b1;
      @(negedge clk);
    end
    check("late_ack_seen", acks - a0, 1);
    check("late_ack_novalid", 32'(got_v), 0);

`ifdef LS_TIMEOUT_EN
    s_mute = 1'b1;
    @(negedge clk);
    v_i = 1'b1; ld_i = 1'b1; st_i = 1'b0;
    f3_i = F3_LW; addr_i = 32'h0;
    @(posedge clk);
    a0 = 0;
    for (int k = 1; k <= 40 && a0 == 0; k++) begin
      @(negedge clk);
      v_i = 1'b0;
      if (val_o) begin
        a0 = k;
        check("tmo_err", 32'(berr_o), 1);
        check("tmo_werd", 32'(werd_o), 0);
      end
    end
    check("tmo_lat", a0, 6);
    @(negedge clk);
    check("tmo_idle", 32'(rdy_o), 1);
    s_mute = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
